// File: rtl/cv32e40p_x_coproc_arbiter.sv
// cv32e40p_x_coproc_arbiter: shares one X-interface issue/result channel among NUM_COPROC coprocessors
module cv32e40p_x_coproc_arbiter #(
  parameter int NUM_COPROC = 2,
  parameter int IDX_W = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [3:0]              issue_id_i,
  output logic                    issue_resp_accept_o,
  output logic                    issue_resp_writeback_o,
  output logic                    issue_resp_loadstore_o,
  output logic [NUM_COPROC-1:0]   cop_issue_valid_o,
  input  logic [NUM_COPROC-1:0]   cop_issue_ready_i,
  input  logic [NUM_COPROC-1:0]   cop_resp_accept_i,
  input  logic [NUM_COPROC-1:0]   cop_resp_writeback_i,
  input  logic [NUM_COPROC-1:0]   cop_resp_loadstore_i,
  input  logic                    commit_valid_i,
  input  logic [3:0]              commit_id_i,
  input  logic                    commit_kill_i,
  input  logic [NUM_COPROC-1:0]   cop_result_valid_i,
  output logic [NUM_COPROC-1:0]   cop_result_ready_o,
  input  logic [NUM_COPROC*4-1:0] cop_result_id_i,
  input  logic [NUM_COPROC*5-1:0] cop_result_rd_i,
  input  logic [NUM_COPROC-1:0]   cop_result_we_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [3:0]              result_id_o,
  output logic [4:0]              result_rd_o,
  output logic                    result_we_o,
  output logic [4:0]              outstanding_o,
  output logic                    multi_accept_o,
  output logic                    spurious_result_o
);
  typedef enum logic {R_IDLE, R_LOCK} state_t;
  state_t state;
  logic [15:0] tab_v;
  logic [IDX_W-1:0] tab_o [16];
  logic [IDX_W-1:0] rr_ptr, lock_g, arb_g, g, owner, hi, lo;
  logic [NUM_COPROC-1:0] own_oh;
  logic busy, issue_hs, res_hs, inc, kill, dec_k, dec_r, any_hi;
  assign busy = tab_v[issue_id_i];
  assign cop_issue_valid_o = {NUM_COPROC{issue_valid_i & ~busy}};
  assign issue_ready_o = ~busy & (&cop_issue_ready_i);
  assign issue_hs = issue_valid_i & issue_ready_o;
  assign own_oh = cop_resp_accept_i & ~(cop_resp_accept_i - NUM_COPROC'(1));
  assign issue_resp_accept_o = |cop_resp_accept_i;
  assign issue_resp_writeback_o = |(cop_resp_writeback_i & own_oh);
  assign issue_resp_loadstore_o = |(cop_resp_loadstore_i & own_oh);
  always_comb begin
    owner = '0;
    for (int i = NUM_COPROC - 1; i >= 0; i--) owner = cop_resp_accept_i[i] ? IDX_W'(i) : owner;
  end
  // Round-robin: lowest requester at or above rr_ptr, else wrap to the lowest requester overall
  always_comb begin
    hi = '0;
    lo = '0;
    any_hi = 1'b0;
    for (int i = NUM_COPROC - 1; i >= 0; i--) begin
      lo = cop_result_valid_i[i] ? IDX_W'(i) : lo;
      if (cop_result_valid_i[i] && IDX_W'(i) >= rr_ptr) begin
        hi = IDX_W'(i);
        any_hi = 1'b1;
      end
    end
    arb_g = any_hi ? hi : lo;
  end
  assign g = (state == R_LOCK) ? lock_g : arb_g;
  always_comb begin
    result_valid_o = 1'b0;
    result_id_o = '0;
    result_rd_o = '0;
    result_we_o = 1'b0;
    cop_result_ready_o = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (g == IDX_W'(i)) begin
        result_valid_o = cop_result_valid_i[i];
        result_id_o = cop_result_id_i[i*4 +: 4];
        result_rd_o = cop_result_rd_i[i*5 +: 5];
        result_we_o = cop_result_we_i[i];
        cop_result_ready_o[i] = result_ready_i;
      end
    end
  end
  assign res_hs = result_valid_o & result_ready_i;
  assign inc = issue_hs & issue_resp_accept_o;
  assign kill = commit_valid_i & commit_kill_i;
  assign dec_k = kill & tab_v[commit_id_i];
  // A kill and a result hitting the same live entry free it only once
  assign dec_r = res_hs & tab_v[result_id_o] & ~(dec_k & (commit_id_i == result_id_o));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tab_v <= '0;
      for (int i = 0; i < 16; i++) tab_o[i] <= '0;
      state <= R_IDLE;
      rr_ptr <= '0;
      lock_g <= '0;
      outstanding_o <= '0;
      multi_accept_o <= 1'b0;
      spurious_result_o <= 1'b0;
    end else begin
      if (kill) tab_v[commit_id_i] <= 1'b0;
      if (res_hs) begin
        tab_v[result_id_o] <= 1'b0;
        rr_ptr <= (g == IDX_W'(NUM_COPROC - 1)) ? '0 : g + IDX_W'(1);
        if (!tab_v[result_id_o] || tab_o[result_id_o] != g) spurious_result_o <= 1'b1;
      end
      if (inc) begin
        tab_v[issue_id_i] <= 1'b1;
        tab_o[issue_id_i] <= owner;
      end
      if (issue_hs && own_oh != cop_resp_accept_i) multi_accept_o <= 1'b1;
      outstanding_o <= outstanding_o + {4'b0, inc} - {4'b0, dec_k} - {4'b0, dec_r};
      if (state == R_IDLE && result_valid_o && !result_ready_i) begin
        state <= R_LOCK;
        lock_g <= g;
      end else if (res_hs) state <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_cv32e40p_x_coproc_arbiter.sv
// tb_cv32e40p_x_coproc_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_cv32e40p_x_coproc_arbiter;
  localparam int N = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic iv, cv, ckill, rready;
  logic [3:0] iid, cid;
  logic [N-1:0] crdy, acc, wb, ls, rv, rwe;
  logic [4*N-1:0] rid;
  logic [5*N-1:0] rrd;
  logic iready, racc, rwb, rls, res_v, res_we, multi, spur;
  logic [N-1:0] civ, crr;
  logic [3:0] res_id;
  logic [4:0] res_rd, outst;
  int n_tests = 0, n_fail = 0;
  cv32e40p_x_coproc_arbiter #(.NUM_COPROC(N), .IDX_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(iv), .issue_ready_o(iready), .issue_id_i(iid),
    .issue_resp_accept_o(racc), .issue_resp_writeback_o(rwb), .issue_resp_loadstore_o(rls),
    .cop_issue_valid_o(civ), .cop_issue_ready_i(crdy),
    .cop_resp_accept_i(acc), .cop_resp_writeback_i(wb), .cop_resp_loadstore_i(ls),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ckill),
    .cop_result_valid_i(rv), .cop_result_ready_o(crr), .cop_result_id_i(rid),
    .cop_result_rd_i(rrd), .cop_result_we_i(rwe),
    .result_valid_o(res_v), .result_ready_i(rready), .result_id_o(res_id),
    .result_rd_o(res_rd), .result_we_o(res_we),
    .outstanding_o(outst), .multi_accept_o(multi), .spurious_result_o(spur)
  );
  // Behavioural model: owner map, live-entry count, sticky flags, round-robin pointer, held grant
  bit mv[16];
  int mo[16];
  int m_out, m_rr, m_lg;
  bit m_multi, m_spur, m_lock;
  bit e_iready, e_acc, e_wb, e_ls, e_rvalid, e_hs, e_rhs, e_we;
  int own, eg;
  logic [N-1:0] e_civ, e_rready;
  logic [3:0] e_rid;
  logic [4:0] e_rd;
  function void m_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      mo[i] = 0;
    end
    m_out = 0; m_rr = 0; m_lg = 0; m_multi = 0; m_spur = 0; m_lock = 0;
  endfunction
  function void calc();
    bit busy, found;
    int c;
    busy = mv[iid];
    e_civ = (iv && !busy) ? '1 : '0;
    e_iready = !busy && (&crdy);
    e_hs = iv && e_iready;
    e_acc = |acc;
    own = 0;
    found = 0;
    for (int i = 0; i < N; i++) if (acc[i] && !found) begin own = i; found = 1; end
    e_wb = e_acc && wb[own];
    e_ls = e_acc && ls[own];
    if (m_lock) eg = m_lg;
    else begin
      eg = m_rr;
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (rv[c] && !found) begin eg = c; found = 1; end
      end
    end
    e_rvalid = rv[eg];
    e_rid = rid[eg*4 +: 4];
    e_rd = rrd[eg*5 +: 5];
    e_we = rwe[eg];
    e_rready = '0;
    if (rready) e_rready[eg] = 1'b1;
    e_rhs = e_rvalid && rready;
  endfunction
  function void advance();
    int na;
    if (e_rhs && (!mv[e_rid] || mo[e_rid] != eg)) m_spur = 1;
    if (cv && ckill && mv[cid]) begin mv[cid] = 0; m_out--; end
    if (e_rhs && mv[e_rid]) begin mv[e_rid] = 0; m_out--; end
    if (e_hs && e_acc) begin mv[iid] = 1; mo[iid] = own; m_out++; end
    na = 0;
    for (int i = 0; i < N; i++) na += int'(acc[i]);
    if (e_hs && na > 1) m_multi = 1;
    if (e_rhs) begin m_rr = (eg + 1) % N; m_lock = 0; end
    else if (!m_lock && e_rvalid) begin m_lock = 1; m_lg = eg; end
  endfunction
  task tick();
    @(posedge clk);
    #1;
  endtask
  task idle();
    iv = 0; iid = 0; crdy = '1; acc = 0; wb = 0; ls = 0; cv = 0; ckill = 0; cid = 0;
    rv = 0; rwe = 0; rid = 0; rrd = 0; rready = 0;
  endtask
  task do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    m_reset();
  endtask
  task test_reset();
    idle();
    rst = 1;
    #3;
    n_tests++; if ({outst, multi, spur, res_v} !== 8'b0) begin n_fail++; $display("FAIL reset_state got out=%0d multi=%b spur=%b rv=%b want 0", outst, multi, spur, res_v); end
    n_tests++; if (iready !== 1'b1) begin n_fail++; $display("FAIL reset_iready_all got %b want 1", iready); end
    crdy = 2'b01;
    #1;
    n_tests++; if (iready !== 1'b0) begin n_fail++; $display("FAIL reset_iready_partial got %b want 0", iready); end
    do_reset();
  endtask
  task test_accept_cop1();
    do_reset();
    iv = 1; iid = 3; acc = 2'b10; wb = 2'b10; ls = 2'b00;
    #1;
    n_tests++; if ({iready, racc, rwb, rls} !== 4'b1110) begin n_fail++; $display("FAIL cop1_issue_resp got %b want 1110", {iready, racc, rwb, rls}); end
    tick();
    n_tests++; if (outst !== 5'd1) begin n_fail++; $display("FAIL cop1_outstanding got %0d want 1", outst); end
    #1;
    n_tests++; if ({iready, civ} !== 3'b000) begin n_fail++; $display("FAIL cop1_busy_stall got %b want 000", {iready, civ}); end
    tick();
    rv = 2'b10; rid = {4'd3, 4'd0}; rready = 1;
    #1;
    n_tests++; if ({res_v, res_id, crr, iready} !== 8'b1_0011_10_0) begin n_fail++; $display("FAIL cop1_result got %b want 10011100", {res_v, res_id, crr, iready}); end
    tick();
    rv = 0; acc = 0;
    #1;
    n_tests++; if ({iready, outst, spur} !== 7'b1_00000_0) begin n_fail++; $display("FAIL cop1_freed got %b want 1000000", {iready, outst, spur}); end
  endtask
  task test_multi_accept();
    do_reset();
    iv = 1; iid = 5; acc = 2'b11; wb = 2'b01;
    #1;
    n_tests++; if (rwb !== 1'b1) begin n_fail++; $display("FAIL multi_owner_wb got %b want 1", rwb); end
    tick();
    iv = 0; acc = 0;
    n_tests++; if ({multi, outst} !== 6'b1_00001) begin n_fail++; $display("FAIL multi_flag got %b want 100001", {multi, outst}); end
    rv = 2'b01; rid = {4'd0, 4'd5}; rready = 1;
    tick();
    rv = 0;
    tick();
    tick();
    n_tests++; if ({multi, spur, outst} !== 7'b1_0_00000) begin n_fail++; $display("FAIL multi_sticky got %b want 1000000", {multi, spur, outst}); end
  endtask
  task test_no_accept();
    do_reset();
    iv = 1; iid = 7; acc = 0; wb = 2'b11; ls = 2'b11;
    #1;
    n_tests++; if ({racc, rwb, rls} !== 3'b000) begin n_fail++; $display("FAIL none_resp got %b want 000", {racc, rwb, rls}); end
    tick();
    iv = 0;
    n_tests++; if ({outst, multi} !== 6'b0) begin n_fail++; $display("FAIL none_outstanding got %b want 000000", {outst, multi}); end
  endtask
  task test_round_robin();
    do_reset();
    rv = 2'b11; rid = {4'hB, 4'hA}; rready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++; if ({res_id, crr} !== ((k % 2) ? 6'b1011_10 : 6'b1010_01)) begin n_fail++; $display("FAIL rr_grant_%0d got %b want %b", k, {res_id, crr}, (k % 2) ? 6'b1011_10 : 6'b1010_01); end
      tick();
    end
  endtask
  task test_lock();
    do_reset();
    rv = 2'b01; rid = {4'd2, 4'd1}; rready = 1;
    tick();
    rready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if ({res_v, res_id, crr} !== 7'b1_0001_00) begin n_fail++; $display("FAIL lock_hold_%0d got %b want 1000100", k, {res_v, res_id, crr}); end
      tick();
    end
    rv = 2'b11;
    #1;
    n_tests++; if (res_id !== 4'd1) begin n_fail++; $display("FAIL lock_frozen got %0d want 1", res_id); end
    tick();
    rready = 1;
    #1;
    n_tests++; if ({res_id, crr} !== 6'b0001_01) begin n_fail++; $display("FAIL lock_release got %b want 000101", {res_id, crr}); end
    tick();
    #1;
    n_tests++; if ({res_id, crr} !== 6'b0010_10) begin n_fail++; $display("FAIL lock_next got %b want 001010", {res_id, crr}); end
    tick();
  endtask
  task test_kill_result();
    do_reset();
    iv = 1; iid = 2; acc = 2'b01;
    tick();
    iid = 4; acc = 2'b10;
    tick();
    iid = 9; acc = 2'b01;
    tick();
    iv = 0; acc = 0;
    n_tests++; if (outst !== 5'd3) begin n_fail++; $display("FAIL kill_setup got %0d want 3", outst); end
    cv = 1; ckill = 1; cid = 2; rv = 2'b10; rid = {4'd4, 4'd0}; rready = 1;
    tick();
    n_tests++; if ({outst, spur} !== 6'b00001_0) begin n_fail++; $display("FAIL kill_plus_result got %b want 000010", {outst, spur}); end
    cv = 0; ckill = 0; rv = 2'b01; rid = {4'd0, 4'd2};
    tick();
    n_tests++; if ({outst, spur} !== 6'b00001_1) begin n_fail++; $display("FAIL killed_id_result got %b want 000011", {outst, spur}); end
    cv = 1; ckill = 1; cid = 9; rid = {4'd0, 4'd9};
    tick();
    idle();
    n_tests++; if (outst !== 5'd0) begin n_fail++; $display("FAIL kill_same_id got %0d want 0", outst); end
  endtask
  task test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 300 == 0) do_reset();
      iv = 1'($urandom); iid = 4'($urandom); crdy = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      acc = N'($urandom); wb = N'($urandom); ls = N'($urandom);
      cv = ($urandom_range(0, 3) == 0); ckill = 1'($urandom); cid = 4'($urandom);
      rv = N'($urandom); rwe = N'($urandom); rid = (4*N)'($urandom); rrd = (5*N)'($urandom);
      rready = ($urandom_range(0, 2) != 0);
      #1;
      calc();
      n_tests++; if ({iready, civ, racc, rwb, rls, res_v} !== {e_iready, e_civ, e_acc, e_wb, e_ls, e_rvalid}) begin n_fail++; $display("FAIL rand_comb cyc %0d got %b want %b", cyc, {iready, civ, racc, rwb, rls, res_v}, {e_iready, e_civ, e_acc, e_wb, e_ls, e_rvalid}); end
      if (e_rvalid) begin
        n_tests++; if ({res_id, res_rd, res_we, crr} !== {e_rid, e_rd, e_we, e_rready}) begin n_fail++; $display("FAIL rand_result cyc %0d got %b want %b", cyc, {res_id, res_rd, res_we, crr}, {e_rid, e_rd, e_we, e_rready}); end
      end
      tick();
      advance();
      n_tests++; if ({outst, multi, spur} !== {5'(m_out), m_multi, m_spur}) begin n_fail++; $display("FAIL rand_state cyc %0d got out=%0d multi=%b spur=%b want out=%0d multi=%b spur=%b", cyc, outst, multi, spur, m_out, m_multi, m_spur); end
    end
  endtask
  initial begin
    test_reset();
    test_accept_cop1();
    test_multi_accept();
    test_no_accept();
    test_round_robin();
    test_lock();
    test_kill_result();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
